// File: rtl/cpu_debug_ctrl.sv
// Debug/sequencing controller for toycpu: byte command stream in, status/PC bytes out.
// Halts, runs or single-steps the core via cpu_run and loads imem while halted.
module cpu_debug_ctrl #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   input  logic [15:0]       pc,
   output logic              cpu_run,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              halted
);

   localparam logic [7:0] OpHalt   = 8'h01;
   localparam logic [7:0] OpRun    = 8'h02;
   localparam logic [7:0] OpStep   = 8'h03;
   localparam logic [7:0] OpWrite  = 8'h04;
   localparam logic [7:0] OpReadPc = 8'h05;
   localparam logic [7:0] StatOk   = 8'h00;
   localparam logic [7:0] StatErr  = 8'hEE;

   typedef enum logic [2:0] {
      StHalted, StRunning, StArg, StStepping, StWrite, StRsp
   } state_e;

   state_e            state;
   logic              ret_run;
   logic              arg_step;
   logic [1:0]        arg_cnt;
   logic [STEP_W:0]   step_cnt;
   logic              rsp_two;
   logic [7:0]        rsp_next;
   logic              cmd_fire;

   assign cmd_ready = (state == StHalted) || (state == StRunning) || (state == StArg);
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StHalted;
         ret_run    <= 1'b0;
         arg_step   <= 1'b0;
         arg_cnt    <= '0;
         step_cnt   <= '0;
         rsp_two    <= 1'b0;
         rsp_next   <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         cpu_run    <= 1'b0;
         halted     <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         case (state)
            StHalted, StRunning: begin
               if (cmd_fire) begin
                  ret_run <= (state == StRunning);
                  rsp_two <= 1'b0;
                  case (cmd_data)
                     OpHalt: begin
                        cpu_run   <= 1'b0;
                        halted    <= 1'b1;
                        ret_run   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= StatOk;
                        state     <= StRsp;
                     end
                     OpRun: begin
                        cpu_run   <= 1'b1;
                        halted    <= 1'b0;
                        ret_run   <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= StatOk;
                        state     <= StRsp;
                     end
                     OpStep: begin
                        arg_step <= 1'b1;
                        arg_cnt  <= 2'd1;
                        state    <= StArg;
                     end
                     OpWrite: begin
                        arg_step <= 1'b0;
                        arg_cnt  <= 2'd3;
                        state    <= StArg;
                     end
                     OpReadPc: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= pc[15:8];
                        rsp_next  <= pc[7:0];
                        rsp_two   <= 1'b1;
                        state     <= StRsp;
                     end
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= StatErr;
                        state     <= StRsp;
                     end
                  endcase
               end
            end
            StArg: begin
               if (cmd_fire) begin
                  arg_cnt <= 2'(arg_cnt - 2'd1);
                  if (arg_step) begin
                     if (ret_run) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= StatErr;
                        state     <= StRsp;
                     end else begin
                        // A zero count encodes the full 2^STEP_W steps.
                        step_cnt <= (cmd_data[STEP_W-1:0] == '0) ? {1'b1, {STEP_W{1'b0}}}
                                                                  : {1'b0, cmd_data[STEP_W-1:0]};
                        cpu_run  <= 1'b1;
                        halted   <= 1'b0;
                        state    <= StStepping;
                     end
                  end else begin
                     case (arg_cnt)
                        2'd3: if (!ret_run) imem_addr <= cmd_data[ADDR_W-1:0];
                        2'd2: if (!ret_run) imem_wdata[15:8] <= cmd_data;
                        default: begin
                           if (ret_run) begin
                              rsp_valid <= 1'b1;
                              rsp_data  <= StatErr;
                              state     <= StRsp;
                           end else begin
                              imem_wdata[7:0] <= cmd_data;
                              imem_we         <= 1'b1;
                              state           <= StWrite;
                           end
                        end
                     endcase
                  end
               end
            end
            StStepping: begin
               step_cnt <= step_cnt - (STEP_W + 1)'(1);
               if (step_cnt == (STEP_W + 1)'(1)) begin
                  cpu_run   <= 1'b0;
                  halted    <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_data  <= StatOk;
                  state     <= StRsp;
               end
            end
            StWrite: begin
               imem_we   <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_data  <= StatOk;
               state     <= StRsp;
            end
            StRsp: begin
               if (rsp_ready) begin
                  if (rsp_two) begin
                     rsp_data <= rsp_next;
                     rsp_two  <= 1'b0;
                  end else begin
                     rsp_valid <= 1'b0;
                     state     <= ret_run ? StRunning : StHalted;
                  end
               end
            end
            default: state <= StHalted;
         endcase
      end
   end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Debug/sequencing controller for the toycpu core. It consumes a byte-wide command stream, typically from a UART receiver, and uses it to halt, run or single-step the processor through a clock-enable. While the core is halted it loads instruction memory through a dedicated write port. Every command returns status or PC bytes on a byte-wide response stream.

Parameters:
ADDR_W, 7, instruction-memory address width (128 words)
STEP_W, 8, width of step counter; count 0 encodes 2^STEP_W steps

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command byte valid
cmd_ready  output  1  command byte accepted when cmd_valid && cmd_ready
cmd_data  input  8  command byte
rsp_valid  output  1  response byte valid
rsp_ready  input  1  response byte consumed when rsp_valid && rsp_ready
rsp_data  output  8  response byte
pc  input  16  current processor PC
cpu_run  output  1  clock-enable to PC register, register file, data memory WE, ALU flags
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  instruction-memory write address
imem_wdata  output  16  instruction-memory write data
halted  output  1  1 when cpu_run is deasserted and no step is in progress

Behaviour:
- Reset (async):
  - State HALTED; cpu_run=0, halted=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - rsp_valid=0, rsp_data=0, cmd_ready=1.
- Command set (first byte = opcode; argument bytes follow):
  - 0x01 HALT: cpu_run=0 from next cycle.
  - 0x02 RUN: cpu_run=1 from next cycle.
  - 0x03 STEP n (1 arg): cpu_run=1 for exactly n cycles (n=0 → 256), then 0.
  - 0x04 WRITE a,hi,lo (3 args): imem[a[ADDR_W-1:0]] = {hi,lo}.
  - 0x05 READPC: response is pc[15:8] then pc[7:0]; pc is sampled in the cycle the opcode is accepted.
  - Any other opcode: no action; status 0xEE.
- Status byte: every command except READPC returns 1 status byte.
  - 0x00 = ok, 0xEE = rejected or unknown.
  - STEP and WRITE are rejected (0xEE) when issued while RUNNING. Their argument bytes are still consumed, and no step or write occurs.
- States:
  - HALTED
  - RUNNING
  - ARG: collecting args; tracks the opcode, the count remaining, and the run state to return to.
  - STEPPING
  - WRITE
  - RSP: emitting 1 or 2 bytes, then returning to HALTED or RUNNING.
- cmd_ready:
  - 1 in HALTED, RUNNING and ARG.
  - 0 in STEPPING, WRITE and RSP.
  - One command is outstanding at a time.
- RUN/HALT timing: cpu_run changes on the clock edge that accepts the opcode. Status is pushed in the same edge; rsp_valid=1 the following cycle.
- RUN while RUNNING or HALT while HALTED: no state change; status 0x00.
- STEP:
  - The edge accepting the count loads the counter and sets cpu_run=1.
  - The counter decrements each cycle; cpu_run drops on the edge where the counter reaches 1→0.
  - The status byte becomes valid in the same cycle cpu_run first reads 0.
  - Total cpu_run-high cycles = n exactly.
- WRITE:
  - imem_addr and imem_wdata are registered as args arrive.
  - imem_we=1 for exactly one cycle, the cycle after the lo byte is accepted; then status.
  - imem_addr and imem_wdata hold their values after the write.
- Response handshake:
  - rsp_data is stable while rsp_valid && !rsp_ready.
  - For READPC the second byte is presented the cycle after the first is taken.
  - Back-to-back responses are allowed when rsp_ready is held high.
- Mid-command reset: async rst aborts any state. cpu_run drops immediately, partial args are discarded, and a pending response is dropped.
- halted = (state path is not RUNNING) && !cpu_run, registered alongside cpu_run.

Test Plan:
- Reset, then READPC with pc=0x0000 and rsp_ready=1 → bytes 0x00,0x00; cpu_run stays 0, halted=1.
- WRITE 0x05,0x12,0x34 while halted → one imem_we pulse with imem_addr=5, imem_wdata=0x1234; status 0x00.
- STEP 3 → cpu_run high for exactly 3 cycles, then status 0x00. STEP 0 → cpu_run high exactly 256 cycles.
- RUN, then WRITE 0x01,0xAA,0xBB → status 0x00 then 0xEE; imem_we never asserts; cpu_run stays 1. A following HALT → cpu_run=0, status 0x00.
- RUN with rsp_ready=0 for 10 cycles → rsp_valid held with rsp_data=0x00 stable; cmd_ready=0 until the byte is taken. Unknown opcode 0x7F → 0xEE.
- Assert rst in the middle of STEP 200 (after 50 cycles) and mid-WRITE (after 2 args) → cpu_run=0 immediately, no imem_we, rsp_valid=0, cmd_ready=1 after reset release.
